// File: rtl/clk_en_sched_pkg.sv
// clk_en_sched_pkg: shared FSM encodings, default counter width and config record for clk_en_sched
package clk_en_sched_pkg;
  localparam int NCNTR_DEF = 8;
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_SYNC = 3'b100
  } state_t;
  typedef struct packed {
    logic [NCNTR_DEF-1:0] period;
    logic [NCNTR_DEF-1:0] width;
    logic                 en;
  } cfg_t;
endpackage

// File: rtl/clk_en_chan.sv
// clk_en_chan: one timebase channel with active/pending config, wrap counter and registered tick/win
module clk_en_chan
  import clk_en_sched_pkg::*;
#(
  parameter int NCntr = NCNTR_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_now,
  input  logic             sync_clr,
  input  logic             wr_pending,
  input  logic [NCntr-1:0] wr_period,
  input  logic [NCntr-1:0] wr_width,
  input  logic             wr_en,
  output logic             pending,
  output logic             wrap,
  output logic             en,
  output logic             en_next,
  output logic             tick,
  output logic             win
);
  logic [NCntr-1:0] period, width, cnt, pnd_period, pnd_width;
  logic             pnd_en;
  always_comb begin
    wrap    = en && cnt == period;
    en_next = load_now ? pnd_en : en;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      period     <= '0;
      width      <= '0;
      en         <= 1'b0;
      pnd_period <= '0;
      pnd_width  <= '0;
      pnd_en     <= 1'b0;
      pending    <= 1'b0;
      cnt        <= '0;
      tick       <= 1'b0;
      win        <= 1'b0;
    end else begin
      cnt     <= (sync_clr || load_now || !en || wrap) ? '0 : cnt + NCntr'(1);
      tick    <= en && cnt == '0;
      win     <= en && cnt < width;
      pending <= wr_pending || (pending && !load_now);
      if (load_now) begin
        period <= pnd_period;
        width  <= pnd_width;
        en     <= pnd_en;
      end
      if (wr_pending) begin
        pnd_period <= wr_period;
        pnd_width  <= wr_width;
        pnd_en     <= wr_en;
      end
    end
  end
endmodule

// File: rtl/clk_en_sched.sv
// clk_en_sched: multi-channel clock-enable scheduler; config writes land on period wrap, sync_req re-phases all
module clk_en_sched
  import clk_en_sched_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int NCntr = NCNTR_DEF
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [$clog2(NCH > 1 ? NCH : 2)-1:0] cfg_ch,
  input  logic [NCntr-1:0]                   cfg_period,
  input  logic [NCntr-1:0]                   cfg_width,
  input  logic                               cfg_en,
  input  logic                               sync_req,
  output logic [NCH-1:0]                     tick,
  output logic [NCH-1:0]                     win,
  output logic                               busy
);
  state_t         state, state_next;
  logic [NCH-1:0] pending, wrap, en, en_next, load_now, wr_pending;
  logic           sync, fire;
  always_comb begin
    sync       = state == ST_SYNC;
    cfg_ready  = !(|pending) && !sync;
    busy       = sync || |pending;
    fire       = cfg_valid && cfg_ready;
    state_next = (sync_req && !sync) ? ST_SYNC : (|en_next ? ST_RUN : ST_IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else state <= state_next;
  end
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    // Out-of-range channel numbers match no slot, so the write is handshaked and dropped.
    assign wr_pending[i] = fire && 32'(cfg_ch) == i;
    assign load_now[i]   = pending[i] && (sync || !en[i] || wrap[i]);
    clk_en_chan #(.NCntr(NCntr)) u_chan (
      .clk       (clk),
      .rstn      (rstn),
      .load_now  (load_now[i]),
      .sync_clr  (sync),
      .wr_pending(wr_pending[i]),
      .wr_period (cfg_period),
      .wr_width  (cfg_width),
      .wr_en     (cfg_en),
      .pending   (pending[i]),
      .wrap      (wrap[i]),
      .en        (en[i]),
      .en_next   (en_next[i]),
      .tick      (tick[i]),
      .win       (win[i])
    );
  end
endmodule

// File: tb/tb_clk_en_sched.sv
// tb_clk_en_sched: directed self-checking bench for clk_en_sched
module tb_clk_en_sched;
  import clk_en_sched_pkg::*;
  logic       clk = 0;
  logic       rstn = 0;
  logic       cfg_valid = 0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_period = '0;
  logic [7:0] cfg_width = '0;
  logic       cfg_en = 0;
  logic       sync_req = 0;
  logic [3:0] tick, win;
  logic       busy;
  int         checks = 0;
  int         failures = 0;

  clk_en_sched #(.NCH(4), .NCntr(8)) dut (
    .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_width(cfg_width), .cfg_en(cfg_en), .sync_req(sync_req),
    .tick(tick), .win(win), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 0;
    cfg_valid = 0;
    sync_req = 0;
    step();
    step();
    rstn = 1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] p, input logic [7:0] w, input logic e);
    int n = 0;
    cfg_valid = 1;
    cfg_ch = ch;
    cfg_period = p;
    cfg_width = w;
    cfg_en = e;
    while (!cfg_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL cfg_write_timeout ch=%0d ready=%b required 1", ch, cfg_ready);
    end
    step();
    cfg_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (tick !== 4'h0) begin failures++; $display("FAIL reset_tick got=%h exp=0", tick); end
    if (win !== 4'h0) begin failures++; $display("FAIL reset_win got=%h exp=0", win); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    if (dut.state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%b exp=%b", dut.state, ST_IDLE); end
  endtask

  task automatic test_basic();
    logic [9:0] ot, ow;
    cfg_write(2'd0, 8'd4, 8'd2, 1'b1);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    step();
    checks += 2;
    if (dut.state !== ST_RUN) begin failures++; $display("FAIL basic_state got=%b exp=%b", dut.state, ST_RUN); end
    if (tick !== 4'h0) begin failures++; $display("FAIL basic_tick_apply got=%h exp=0", tick); end
    for (int i = 0; i < 10; i++) begin
      step();
      ot[i] = tick[0];
      ow[i] = win[0];
    end
    checks += 2;
    if (ot !== 10'b0000100001) begin failures++; $display("FAIL basic_tick_seq got=%b exp=0000100001", ot); end
    if (ow !== 10'b0001100011) begin failures++; $display("FAIL basic_win_seq got=%b exp=0001100011", ow); end
  endtask

  task automatic test_update();
    int nt = 0, nw = 0;
    step();
    step();
    cfg_write(2'd0, 8'd9, 8'd2, 1'b1);
    checks += 2;
    if (cfg_ready !== 1'b0) begin failures++; $display("FAIL upd_ready_hold got=%b exp=0", cfg_ready); end
    if (busy !== 1'b1) begin failures++; $display("FAIL upd_busy_hold got=%b exp=1", busy); end
    step();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL upd_busy_prewrap got=%b exp=1", busy); end
    step();
    checks += 3;
    if (busy !== 1'b0) begin failures++; $display("FAIL upd_busy_after got=%b exp=0", busy); end
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL upd_ready_after got=%b exp=1", cfg_ready); end
    if (tick[0] !== 1'b0) begin failures++; $display("FAIL upd_tick_wrap got=%b exp=0", tick[0]); end
    step();
    checks++;
    if (tick[0] !== 1'b1) begin failures++; $display("FAIL upd_tick_start got=%b exp=1", tick[0]); end
    for (int i = 0; i < 9; i++) begin
      step();
      nt += int'(tick[0]);
      nw += int'(win[0]);
    end
    checks += 2;
    if (nt != 0) begin failures++; $display("FAIL upd_tick_gap got=%0d exp=0", nt); end
    if (nw != 1) begin failures++; $display("FAIL upd_win_count got=%0d exp=1", nw); end
    step();
    checks++;
    if (tick[0] !== 1'b1) begin failures++; $display("FAIL upd_tick_period10 got=%b exp=1", tick[0]); end
  endtask

  task automatic test_sync();
    int n0 = 0, n1 = 0;
    do_reset();
    cfg_write(2'd0, 8'd2, 8'd1, 1'b1);
    cfg_write(2'd1, 8'd6, 8'd1, 1'b1);
    step();
    step();
    step();
    sync_req = 1;
    step();
    sync_req = 0;
    checks += 2;
    if (dut.state !== ST_SYNC) begin failures++; $display("FAIL sync_state got=%b exp=%b", dut.state, ST_SYNC); end
    if (cfg_ready !== 1'b0) begin failures++; $display("FAIL sync_ready got=%b exp=0", cfg_ready); end
    step();
    checks += 3;
    if (dut.state !== ST_RUN) begin failures++; $display("FAIL sync_exit got=%b exp=%b", dut.state, ST_RUN); end
    if (busy !== 1'b0) begin failures++; $display("FAIL sync_busy got=%b exp=0", busy); end
    if (tick !== 4'h0) begin failures++; $display("FAIL sync_tick_pre got=%h exp=0", tick); end
    step();
    checks++;
    if (tick !== 4'b0011) begin failures++; $display("FAIL sync_tick_align got=%b exp=0011", tick); end
    for (int i = 0; i < 21; i++) begin
      step();
      n0 += int'(tick[0]);
      n1 += int'(tick[1]);
    end
    checks += 3;
    if (n0 != 7) begin failures++; $display("FAIL sync_tick0_count got=%0d exp=7", n0); end
    if (n1 != 3) begin failures++; $display("FAIL sync_tick1_count got=%0d exp=3", n1); end
    if (tick !== 4'b0011) begin failures++; $display("FAIL sync_tick_realign got=%b exp=0011", tick); end
  endtask

  task automatic test_edges();
    int t0 = 0, w0 = 0, w1 = 0, n = 8;
    do_reset();
    cfg_write(2'd0, 8'd0, 8'd0, 1'b1);
    cfg_write(2'd1, 8'd3, 8'd8, 1'b1);
    cfg_write(2'd2, 8'd255, 8'd1, 1'b1);
    step();
    step();
    checks++;
    if (tick[2] !== 1'b1) begin failures++; $display("FAIL edge_p255_first got=%b exp=1", tick[2]); end
    for (int i = 0; i < 8; i++) begin
      step();
      t0 += int'(tick[0]);
      w0 += int'(win[0]);
      w1 += int'(win[1]);
    end
    checks += 3;
    if (t0 != 8) begin failures++; $display("FAIL edge_p0_tick got=%0d exp=8", t0); end
    if (w0 != 0) begin failures++; $display("FAIL edge_w0_win got=%0d exp=0", w0); end
    if (w1 != 8) begin failures++; $display("FAIL edge_wgtp_win got=%0d exp=8", w1); end
    while (n < 300) begin
      step();
      n++;
      if (tick[2]) break;
    end
    checks++;
    if (n != 256) begin failures++; $display("FAIL edge_p255_period got=%0d exp=256", n); end
  endtask

  task automatic test_sync_cfg();
    do_reset();
    cfg_write(2'd0, 8'd3, 8'd1, 1'b1);
    step();
    step();
    step();
    cfg_valid = 1;
    cfg_ch = 2'd1;
    cfg_period = 8'd3;
    cfg_width = 8'd1;
    cfg_en = 1;
    sync_req = 1;
    checks++;
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL synccfg_ready got=%b exp=1", cfg_ready); end
    step();
    cfg_valid = 0;
    sync_req = 0;
    checks += 2;
    if (dut.state !== ST_SYNC) begin failures++; $display("FAIL synccfg_state got=%b exp=%b", dut.state, ST_SYNC); end
    if (busy !== 1'b1) begin failures++; $display("FAIL synccfg_busy got=%b exp=1", busy); end
    step();
    checks += 2;
    if (dut.state !== ST_RUN) begin failures++; $display("FAIL synccfg_exit got=%b exp=%b", dut.state, ST_RUN); end
    if (busy !== 1'b0) begin failures++; $display("FAIL synccfg_busy_clr got=%b exp=0", busy); end
    step();
    checks++;
    if (tick !== 4'b0011) begin failures++; $display("FAIL synccfg_align got=%b exp=0011", tick); end
    step();
    checks++;
    if (tick !== 4'b0000) begin failures++; $display("FAIL synccfg_gap got=%b exp=0000", tick); end
    step();
    step();
    step();
    checks++;
    if (tick !== 4'b0011) begin failures++; $display("FAIL synccfg_realign got=%b exp=0011", tick); end
  endtask

  task automatic test_reset_mid();
    cfg_write(2'd0, 8'd9, 8'd2, 1'b1);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_pre got=%b exp=1", busy); end
    rstn = 0;
    step();
    checks += 5;
    if (tick !== 4'h0) begin failures++; $display("FAIL rmid_tick got=%h exp=0", tick); end
    if (win !== 4'h0) begin failures++; $display("FAIL rmid_win got=%h exp=0", win); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", cfg_ready); end
    if (dut.state !== ST_IDLE) begin failures++; $display("FAIL rmid_state got=%b exp=%b", dut.state, ST_IDLE); end
    rstn = 1;
    step();
    step();
    step();
    checks += 2;
    if (tick !== 4'h0) begin failures++; $display("FAIL rmid_discard_tick got=%h exp=0", tick); end
    if (dut.state !== ST_IDLE) begin failures++; $display("FAIL rmid_discard_state got=%b exp=%b", dut.state, ST_IDLE); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_update();
    test_sync();
    test_edges();
    test_sync_cfg();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
